// File: rtl/henon_iter_controller.sv
// -----------------------------------------------------------------------------
// henon_iter_controller
//
// Initiator side of the Henon step core's start/done handshake. Runs n_iter_i
// chained Q1.31 Henon iterations, feeding each core result back as the next
// operand pair. When all iterations are done it maps the final x onto a tarot
// card index 0..77. A core that never answers is abandoned after
// TIMEOUT_CYCLES and reported with an error pulse.
//
// Optional feature macro: HENON_PERTURB_EN
//   defined   : core_perturb_o = sign-extended 16-bit Galois LFSR word
//               (x^16+x^14+x^13+x^11+1) >>> PERTURB_SHIFT; the LFSR steps once
//               per launch.
//   undefined : core_perturb_o is constant 0 and no LFSR is built.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   host_start_i        one-cycle request, sampled only while idle
//   seed_x_i, seed_y_i  initial x/y (Q1.31)
//   a_coef_i, b_coef_i  map coefficients (Q1.31), latched at accept
//   n_iter_i            iteration count, latched at accept
//   busy_o              high from accept until result_valid_o or error_o
//   result_valid_o      one-cycle pulse; finals held until the next accept
//   error_o             one-cycle pulse on core timeout
//   x_final_o, y_final_o, card_idx_o   results
//   core_start_o        one-cycle start pulse to the core
//   core_x_in_o, core_y_in_o, core_a_o, core_b_o, core_perturb_o  core operands
//   core_x_out_i, core_y_out_i, core_done_i                       core results
//
// State table
//   IDLE   | waiting for host_start_i
//   LAUNCH | core_start_o high for one cycle, timeout counter armed
//   WAIT   | waiting for core_done_i, timeout counting down
//   MAP    | finals and card index registered
//   DONE   | result_valid_o pulse
// -----------------------------------------------------------------------------
module henon_iter_controller #(
  parameter int          ITER_W         = 16,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          PERTURB_SHIFT  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_start_i,
  input  logic [31:0]       seed_x_i,
  input  logic [31:0]       seed_y_i,
  input  logic [31:0]       a_coef_i,
  input  logic [31:0]       b_coef_i,
  input  logic [ITER_W-1:0] n_iter_i,
  output logic              busy_o,
  output logic              result_valid_o,
  output logic              error_o,
  output logic [31:0]       x_final_o,
  output logic [31:0]       y_final_o,
  output logic [6:0]        card_idx_o,
  output logic              core_start_o,
  output logic [31:0]       core_x_in_o,
  output logic [31:0]       core_y_in_o,
  output logic [31:0]       core_a_o,
  output logic [31:0]       core_b_o,
  output logic [31:0]       core_perturb_o,
  input  logic [31:0]       core_x_out_i,
  input  logic [31:0]       core_y_out_i,
  input  logic              core_done_i
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_MAP, S_DONE} state_t;

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_q, state_d;
  logic [31:0]       x_q, x_d, y_q, y_d, a_q, a_d, b_q, b_d;
  logic [31:0]       xf_q, xf_d, yf_q, yf_d;
  logic [6:0]        card_q, card_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              busy_q, busy_d, err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      xf_q    <= '0;
      yf_q    <= '0;
      card_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      a_q     <= a_d;
      b_q     <= b_d;
      xf_q    <= xf_d;
      yf_q    <= yf_d;
      card_q  <= card_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    a_d     = a_q;
    b_d     = b_q;
    xf_d    = xf_q;
    yf_d    = yf_q;
    card_d  = card_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (host_start_i) begin
          x_d     = seed_x_i;
          y_d     = seed_y_i;
          a_d     = a_coef_i;
          b_d     = b_coef_i;
          cnt_d   = n_iter_i;
          busy_d  = 1'b1;
          state_d = (n_iter_i == '0) ? S_MAP : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tmo_d   = TMO_W'(TIMEOUT_CYCLES - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last permitted cycle still wins over timeout.
        if (core_done_i) begin
          x_d     = core_x_out_i;
          y_d     = core_y_out_i;
          cnt_d   = cnt_q - ITER_W'(1);
          state_d = (cnt_q == ITER_W'(1)) ? S_MAP : S_LAUNCH;
        end else if (tmo_q <= TMO_W'(1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      S_MAP: begin
        // Offset-binary x scaled by 78; the top 7 bits of the 39-bit product
        // are always 0..77.
        card_d  = 7'(({7'd0, x_q ^ 32'h8000_0000} * 39'd78) >> 32);
        xf_d    = x_q;
        yf_d    = y_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef HENON_PERTURB_EN
  // The LFSR steps on entry to LAUNCH so the perturb operand is already
  // stable during the start pulse and stays put until done is sampled.
  logic [15:0]        lfsr_q, lfsr_d, lfsr_step;
  logic signed [31:0] lfsr_sx;
  logic [31:0]        perturb_q, perturb_d;

  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  assign lfsr_sx   = {{16{lfsr_step[15]}}, lfsr_step};

  always_comb begin
    lfsr_d    = lfsr_q;
    perturb_d = perturb_q;
    if (state_d == S_LAUNCH) begin
      lfsr_d    = lfsr_step;
      perturb_d = 32'(lfsr_sx >>> PERTURB_SHIFT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q    <= LFSR_SEED;
      perturb_q <= '0;
    end else begin
      lfsr_q    <= lfsr_d;
      perturb_q <= perturb_d;
    end
  end

  assign core_perturb_o = perturb_q;
`else
  assign core_perturb_o = 32'd0;
`endif

  assign busy_o         = busy_q;
  assign result_valid_o = (state_q == S_DONE);
  assign error_o        = err_q;
  assign x_final_o      = xf_q;
  assign y_final_o      = yf_q;
  assign card_idx_o     = card_q;
  assign core_start_o   = (state_q == S_LAUNCH);
  assign core_x_in_o    = x_q;
  assign core_y_in_o    = y_q;
  assign core_a_o       = a_q;
  assign core_b_o       = b_q;

endmodule
